// File: rtl/tcam_loader_pkg.sv
// Shared types and helpers for the routing TCAM loader.
// State encoding and key/mask/dst word packing.
package tcam_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READY = 3'd4
  } state_e;

  // Places hi above the low w bits taken from lo.
  function automatic logic [31:0] pack_pair(
    input logic [15:0] hi,
    input logic [15:0] lo,
    input int unsigned w
  );
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return ({16'd0, hi} << w) | ({16'd0, lo} & m);
  endfunction

endpackage

// File: rtl/tcam_route_loader.sv
// Flushes the routing TCAM, writes route entries from address 0 up,
// then hands the array over for PacketID lookups.
module tcam_route_loader
  import tcam_loader_pkg::*;
#(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int Words       = 16,
  parameter int FlushCycles = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   ent_valid,
  output logic                   ent_ready,
  input  logic [ID_Width-1:0]    ent_key,
  input  logic [ID_Width-1:0]    ent_key_mask,
  input  logic [ID_Width-1:0]    ent_dst,
  input  logic                   ent_last,
  output logic                   CS,
  output logic                   FLUSH,
  output logic                   VBE,
  output logic                   DCS,
  output logic                   WR,
  output logic                   VBI,
  output logic [Bits-1:0]        Data_In,
  output logic [Bits-1:0]        Mask_In,
  output logic [AddressSize-1:0] Addr_In,
  output logic                   busy,
  output logic                   tbl_ready,
  output logic [AddressSize:0]   n_loaded,
  output logic                   err_ovf
);

  localparam int FCW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam logic [FCW-1:0] FC_INIT = FCW'(FlushCycles - 1);
  localparam logic [AddressSize:0] WORDS_W = (AddressSize + 1)'(Words);

  state_e                 state_q;
  logic [FCW-1:0]         fcnt_q;
  logic [AddressSize:0]   wr_ptr_q;
  logic [AddressSize:0]   n_loaded_q;
  logic                   err_q;
  logic                   last_q;
  logic [Bits-1:0]        data_q;
  logic [Bits-1:0]        mask_q;
  logic [AddressSize-1:0] addr_q;
  logic [Bits-1:0]        data_w;
  logic [Bits-1:0]        mask_w;
  logic                   in_wr;

  assign data_w = Bits'(pack_pair(16'(ent_key), 16'(ent_dst), ID_Width));
  assign mask_w = Bits'(pack_pair(16'(ent_key_mask), 16'hFFFF, ID_Width));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      n_loaded_q <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_READY: begin
          if (start) begin
            state_q    <= ST_FLUSH;
            fcnt_q     <= FC_INIT;
            wr_ptr_q   <= '0;
            n_loaded_q <= '0;
            err_q      <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == '0) state_q <= ST_LOAD;
          else fcnt_q <= fcnt_q - 1'b1;
        end
        ST_LOAD: begin
          if (ent_valid) begin
            if (wr_ptr_q == WORDS_W) begin
              // Table full: drop, flag, still honour the end marker.
              err_q <= 1'b1;
              if (ent_last) state_q <= ST_READY;
            end else begin
              data_q  <= data_w;
              mask_q  <= mask_w;
              addr_q  <= wr_ptr_q[AddressSize-1:0];
              last_q  <= ent_last;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          n_loaded_q <= wr_ptr_q + 1'b1;
          state_q    <= last_q ? ST_READY : ST_LOAD;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_wr     = (state_q == ST_WRITE);
  assign CS        = (state_q != ST_IDLE);
  assign FLUSH     = (state_q == ST_FLUSH);
  assign ent_ready = (state_q == ST_LOAD);
  assign tbl_ready = (state_q == ST_READY);
  assign busy      = FLUSH | ent_ready | in_wr;
  assign VBE       = in_wr;
  assign DCS       = in_wr;
  assign WR        = in_wr;
  assign VBI       = in_wr;
  assign Data_In   = in_wr ? data_q : '0;
  assign Mask_In   = in_wr ? mask_q : '0;
  assign Addr_In   = in_wr ? addr_q : '0;
  assign n_loaded  = n_loaded_q;
  assign err_ovf   = err_q;

endmodule

// File: doc/tcam_route_loader.md
Name: tcam_route_loader

Overview:
- Programs the routing TCAM (the lookup wrapper keyed by PacketID that returns DstID) from a stream of route entries.
- Sequence: flush the array, write entries at consecutive addresses from 0, then release the TCAM for lookups.
- Drives the wrapper's write-side ports: CS, FLUSH, VBE, DCS, WR, VBI, Data_In, Mask_In, Addr_In.
- Sits between the config/host interface and the routing memory.

Parameters:
- ID_Width, 4, width of PacketID key and DstID payload.
- AddressSize, 4, TCAM address width.
- Bits, 8, TCAM word width; must equal 2*ID_Width.
- Words, 16, TCAM depth; must be ≤ 2**AddressSize.
- FlushCycles, 2, number of cycles FLUSH is held asserted (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a flush+load sequence; ignored unless in IDLE or READY.
- ent_valid  in  1  route entry valid.
- ent_ready  out  1  loader accepts an entry.
- ent_key  in  ID_Width  PacketID to match.
- ent_key_mask  in  ID_Width  1 = compare this key bit, 0 = don't care.
- ent_dst  in  ID_Width  destination ID returned on hit.
- ent_last  in  1  marks the final entry of the table.
- CS  out  1  TCAM chip select.
- FLUSH  out  1  TCAM flush.
- VBE  out  1  valid-bit write enable.
- DCS  out  1  data chip select.
- WR  out  1  TCAM write strobe.
- VBI  out  1  valid-bit write value.
- Data_In  out  Bits  {key, dst}.
- Mask_In  out  Bits  {key_mask, all ones}.
- Addr_In  out  AddressSize  write address.
- busy  out  1  sequence in progress.
- tbl_ready  out  1  table loaded; lookups valid.
- n_loaded  out  AddressSize+1  entries actually written.
- err_ovf  out  1  sticky: entry arrived when the table was full.

Behaviour:
- Reset: all outputs 0. State IDLE, wr_ptr = 0, err_ovf = 0.
- FSM states: IDLE, FLUSH, LOAD, WRITE, READY.

IDLE:
- CS = 0.
- start → FLUSH. Clears wr_ptr, n_loaded, err_ovf and tbl_ready.

FLUSH:
- CS = 1, FLUSH = 1, WR = 0.
- Lasts exactly FlushCycles cycles (down-counter), then → LOAD.

LOAD:
- CS = 1, ent_ready = 1, all TCAM strobes 0.
- On ent_valid && ent_ready:
  - wr_ptr < Words: capture Data_In = {ent_key, ent_dst}, Mask_In = {ent_key_mask, ID_Width'1s}, Addr_In = wr_ptr[AddressSize-1:0] into registers, then → WRITE.
  - wr_ptr == Words: drop the entry, set err_ovf; → READY if ent_last, else stay in LOAD.

WRITE (exactly 1 cycle):
- CS = DCS = VBE = VBI = WR = 1; ent_ready = 0.
- Data_In, Mask_In and Addr_In are held stable from registers.
- Then wr_ptr++ and n_loaded = wr_ptr+1.
- → READY if the captured entry had ent_last, else → LOAD.

READY:
- CS = 1, tbl_ready = 1, WR = FLUSH = 0. The wrapper runs lookups.
- start → FLUSH, which reloads the table.

Timing:
- Throughput: one entry per 2 cycles.
- Latency from accept to WR asserted: 1 cycle.

Other rules:
- busy = 1 in FLUSH, LOAD and WRITE.
- Data_In, Mask_In and Addr_In are 0 outside WRITE.
- start while busy: ignored, no effect.
- An ent_last entry is written normally even when wr_ptr == Words-1.
- ent_valid outside LOAD: not accepted, because ent_ready = 0.
- rst mid-sequence: back to IDLE next edge, all outputs 0. The TCAM contents are undefined until the next start.

Decomposition:
- Package tcam_loader_pkg holds the state enum (IDLE, FLUSH, LOAD, WRITE, READY) and a function that packs key/mask/dst into Data_In and Mask_In.
- No sub-module. The flush down-counter and wr_ptr live inline.

Test Plan:
- Reset, then start, then 3 entries (key 4'h3/mask 4'hF/dst 4'h9, key 4'h5/dst 4'h2, key 4'hA/dst 4'h7 with last) → FLUSH high 2 cycles; WR pulses at Addr 0,1,2 with Data_In 8'h39, 8'h52, 8'hA7 and Mask_In 8'hFF; tbl_ready = 1; n_loaded = 3.
- Wildcard entry: key 4'h8, mask 4'h8, dst 4'h4 → Mask_In = 8'h8F. A lookup of PacketID 4'hC then returns DstID 4'h4.
- 17 entries, last on the 17th → 16 writes at Addr 0..15; 17th dropped; err_ovf = 1; n_loaded = 16; READY reached.
- ent_valid held high continuously → ent_ready alternates 1/0; exactly one WR per accepted entry; no entry lost.
- start during LOAD → ignored; load continues. start in READY → new FLUSH; err_ovf and n_loaded cleared.
- rst asserted during WRITE → next cycle all outputs 0 and state IDLE. Fresh start works normally.
